// File: rtl/dataover_event_tracker.sv
// Threshold-flag consumer: encodes over_100/over_200 into a 3-zone level and queues zone crossings.
// DATAOVER_EVT_DATA_EN: when defined, in_data is stored with each event; otherwise ev_data is tied to 0.
module dataover_event_tracker #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              data_over_100,
  input  logic              data_over_200,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [1:0]        ev_level,
  output logic              ev_rising,
  output logic [TS_W-1:0]   ev_ts,
  output logic [DATA_W-1:0] ev_data,
  output logic              overflow,
  output logic              flag_err,
  output logic [7:0]        drop_cnt,
  input  logic              clr_sticky
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  typedef struct packed {
    logic [1:0]        level;
    logic              rising;
    logic [TS_W-1:0]   ts;
`ifdef DATAOVER_EVT_DATA_EN
    logic [DATA_W-1:0] data;
`endif
  } ev_t;

  state_t          state, state_n;
  logic [1:0]      prev_zone, zone;
  logic            legal, smp_ok, smp_bad;
  logic            zone_ld, push, pop, drop;
  logic [TS_W-1:0] ts;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full;
  ev_t             mem [DEPTH];
  ev_t             wr_ev, head;

  // free-running timestamp
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ts <= '0;
    else        ts <= ts + 1'b1;

  // pair 10 (over_200 without over_100) is inconsistent and ignored
  assign legal   = !(data_over_200 && !data_over_100);
  assign zone    = data_over_200 ? 2'd2 : (data_over_100 ? 2'd1 : 2'd0);
  assign smp_ok  = in_valid && legal;
  assign smp_bad = in_valid && !legal;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_INIT;
      prev_zone <= '0;
    end else begin
      state <= state_n;
      if (zone_ld) prev_zone <= zone;
    end

  always_comb begin
    state_n = state;
    zone_ld = 1'b0;
    push    = 1'b0;
    case (state)
      S_INIT: if (smp_ok) begin
        zone_ld = 1'b1;
        state_n = S_TRACK;
      end
      S_TRACK: if (smp_ok && zone != prev_zone) begin
        zone_ld = 1'b1;
        push    = 1'b1;
      end
      default: state_n = S_INIT;
    endcase
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ev_ready;
  // a same-cycle pop frees the slot, so a full buffer still accepts the push
  assign drop  = push && full && !pop;

  always_comb begin
    wr_ev        = '0;
    wr_ev.level  = zone;
    wr_ev.rising = (zone > prev_zone);
    wr_ev.ts     = ts;
`ifdef DATAOVER_EVT_DATA_EN
    wr_ev.data   = in_data;
`endif
  end

  always_ff @(posedge clk)
    if (push && !drop) mem[wr_ptr[AW-1:0]] <= wr_ev;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !drop) wr_ptr <= wr_ptr + 1'b1;
      if (pop)           rd_ptr <= rd_ptr + 1'b1;
    end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign ev_valid  = !empty;
  assign ev_level  = ev_valid ? head.level  : 2'd0;
  assign ev_rising = ev_valid ? head.rising : 1'b0;
  assign ev_ts     = ev_valid ? head.ts     : '0;
`ifdef DATAOVER_EVT_DATA_EN
  assign ev_data   = ev_valid ? head.data   : '0;
`else
  logic unused_in_data;
  assign unused_in_data = ^in_data;
  assign ev_data        = '0;
`endif

  // set conditions take priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow <= 1'b0;
      flag_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)            overflow <= 1'b1;
      else if (clr_sticky) overflow <= 1'b0;
      if (smp_bad)         flag_err <= 1'b1;
      else if (clr_sticky) flag_err <= 1'b0;
      if (drop)            drop_cnt <= clr_sticky ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
      else if (clr_sticky) drop_cnt <= '0;
    end
endmodule

// File: tb/tb_dataover_event_tracker.sv
// Directed table-driven bench for dataover_event_tracker (TS_W = 4 so the timestamp wraps).
module tb_dataover_event_tracker;
  localparam int DATA_W = 32;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, data_over_100, data_over_200, ev_ready, clr_sticky;
  logic [DATA_W-1:0] in_data;
  logic              ev_valid, ev_rising, overflow, flag_err;
  logic [1:0]        ev_level;
  logic [TS_W-1:0]   ev_ts;
  logic [DATA_W-1:0] ev_data;
  logic [7:0]        drop_cnt;

  dataover_event_tracker #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .data_over_100(data_over_100), .data_over_200(data_over_200),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_level(ev_level),
    .ev_rising(ev_rising), .ev_ts(ev_ts), .ev_data(ev_data),
    .overflow(overflow), .flag_err(flag_err), .drop_cnt(drop_cnt),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  f;    // {over_200, over_100}
    logic        rdy;
    logic        clr;
    logic        ev_v;
    logic [1:0]  lvl;
    logic        ris;
    logic [3:0]  ts;
    logic [31:0] ed;
    logic        ovf;
    logic        ferr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vec[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(int v, int d, int f, int rdy, int clr,
                              int ev_v, int lvl, int ris, int ts, int ed,
                              int ovf, int ferr, int cnt);
    vec_t r;
    r.v = 1'(v); r.d = 32'(d); r.f = 2'(f); r.rdy = 1'(rdy); r.clr = 1'(clr);
    r.ev_v = 1'(ev_v); r.lvl = 2'(lvl); r.ris = 1'(ris); r.ts = 4'(ts); r.ed = 32'(ed);
    r.ovf = 1'(ovf); r.ferr = 1'(ferr); r.cnt = 8'(cnt);
    return r;
  endfunction

  task automatic check(input vec_t e, input string name);
    logic [31:0] exp_d;
`ifdef DATAOVER_EVT_DATA_EN
    exp_d = e.ed;
`else
    exp_d = '0;
`endif
    n_vec++;
    if (ev_valid !== e.ev_v || ev_level !== e.lvl || ev_rising !== e.ris ||
        ev_ts !== e.ts || ev_data !== exp_d || overflow !== e.ovf ||
        flag_err !== e.ferr || drop_cnt !== e.cnt) begin
      n_miss++;
      $display("FAIL %s: got v=%0b lvl=%0d r=%0b ts=%0d d=%0d ovf=%0b ferr=%0b cnt=%0d, want v=%0b lvl=%0d r=%0b ts=%0d d=%0d ovf=%0b ferr=%0b cnt=%0d",
               name, ev_valid, ev_level, ev_rising, ev_ts, ev_data, overflow, flag_err, drop_cnt,
               e.ev_v, e.lvl, e.ris, e.ts, exp_d, e.ovf, e.ferr, e.cnt);
    end
  endtask

  // drive at a falling edge, check at the next falling edge
  task automatic apply(input vec_t e, input string name);
    in_valid      = e.v;
    in_data       = e.d;
    data_over_200 = e.f[1];
    data_over_100 = e.f[0];
    ev_ready      = e.rdy;
    clr_sticky    = e.clr;
    @(negedge clk);
    check(e, name);
  endtask

  initial begin
    //               v  data f   rdy clr  ev_v lvl r ts  data  ovf ferr cnt
    // baseline then rising/rising/falling, one cycle apart
    vec.push_back(mk(1,  50, 0, 1, 0,   0, 0, 0,  0,   0,  0, 0, 0));  // 0
    vec.push_back(mk(1, 150, 1, 1, 0,   1, 1, 1,  1, 150,  0, 0, 0));
    vec.push_back(mk(1, 250, 3, 1, 0,   1, 2, 1,  2, 250,  0, 0, 0));
    vec.push_back(mk(1,  90, 0, 1, 0,   1, 0, 0,  3,  90,  0, 0, 0));
    vec.push_back(mk(0,   0, 0, 1, 0,   0, 0, 0,  0,   0,  0, 0, 0));
    // overflow: 6 crossings with ready low
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 1, 1,  5, 150,  0, 0, 0));  // 5
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1,  5, 150,  0, 0, 0));
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 1, 1,  5, 150,  0, 0, 0));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1,  5, 150,  0, 0, 0));
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 1, 1,  5, 150,  1, 0, 1));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1,  5, 150,  1, 0, 2));  // 10
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 0, 0,  6,  50,  1, 0, 2));
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 1, 1,  7, 150,  1, 0, 2));
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 0, 0,  8,  50,  1, 0, 2));
    // last pop with a push at ts=14, then wrap: next push at ts=0
    vec.push_back(mk(1, 150, 1, 1, 0,   1, 1, 1, 14, 150,  1, 0, 2));
    vec.push_back(mk(0,   0, 0, 0, 0,   1, 1, 1, 14, 150,  1, 0, 2));  // 15
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1, 14, 150,  1, 0, 2));
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 1, 1, 14, 150,  1, 0, 2));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1, 14, 150,  1, 0, 2));
    // full with simultaneous pop: no drop, buffer stays full
    vec.push_back(mk(1, 150, 1, 1, 0,   1, 0, 0,  0,  50,  1, 0, 2));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 0, 0,  0,  50,  1, 0, 3));  // 20
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 1, 1,  1, 150,  1, 0, 3));
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 0, 0,  2,  50,  1, 0, 3));
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 1, 1,  3, 150,  1, 0, 3));
    vec.push_back(mk(0,   0, 0, 1, 0,   0, 0, 0,  0,   0,  1, 0, 3));
    vec.push_back(mk(0,   0, 0, 1, 1,   0, 0, 0,  0,   0,  0, 0, 0));  // 25
    // clear coincident with a drop: drop wins
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 1, 1, 10, 150,  0, 0, 0));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1, 10, 150,  0, 0, 0));
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 1, 1, 10, 150,  0, 0, 0));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 1, 1, 10, 150,  0, 0, 0));
    vec.push_back(mk(1, 150, 1, 0, 1,   1, 1, 1, 10, 150,  1, 0, 1));  // 30
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 0, 0, 11,  50,  1, 0, 1));
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 1, 1, 12, 150,  1, 0, 1));
    vec.push_back(mk(0,   0, 0, 1, 0,   1, 0, 0, 13,  50,  1, 0, 1));
    vec.push_back(mk(0,   0, 0, 1, 0,   0, 0, 0,  0,   0,  1, 0, 1));
    // illegal pair in zone 1, then 01 gives no event
    vec.push_back(mk(1, 180, 2, 1, 0,   0, 0, 0,  0,   0,  1, 1, 1));  // 35
    vec.push_back(mk(1, 150, 1, 1, 0,   0, 0, 0,  0,   0,  1, 1, 1));
    vec.push_back(mk(0,   0, 0, 1, 1,   0, 0, 0,  0,   0,  0, 0, 0));
    vec.push_back(mk(1, 180, 2, 1, 1,   0, 0, 0,  0,   0,  0, 1, 0));
    vec.push_back(mk(1, 250, 3, 1, 0,   1, 2, 1,  7, 250,  0, 1, 0));
    vec.push_back(mk(0,   0, 0, 1, 0,   0, 0, 0,  0,   0,  0, 1, 0));  // 40
    // 2 -> 0 jump is a single event
    vec.push_back(mk(1,  50, 0, 1, 0,   1, 0, 0,  9,  50,  0, 1, 0));
    vec.push_back(mk(0,   0, 0, 1, 0,   0, 0, 0,  0,   0,  0, 1, 0));
    // buffer 3 events ahead of a mid-stream reset
    vec.push_back(mk(1, 250, 3, 0, 0,   1, 2, 1, 11, 250,  0, 1, 0));
    vec.push_back(mk(1,  50, 0, 0, 0,   1, 2, 1, 11, 250,  0, 1, 0));
    vec.push_back(mk(1, 150, 1, 0, 0,   1, 2, 1, 11, 250,  0, 1, 0));  // 45

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; data_over_100 = 1'b0;
    data_over_200 = 1'b0; ev_ready = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0), "reset");
    rst_n = 1'b1;

    foreach (vec[i]) apply(vec[i], $sformatf("vec%0d", i));

    // mid-stream reset: buffered events and stickies discarded
    rst_n = 1'b0;
    #1;
    check(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0), "midreset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 250, 3, 1, 0,  0, 0, 0, 0,  0,  0, 0, 0), "rebaseline");
    apply(mk(1,  50, 0, 1, 0,  1, 0, 0, 1, 50,  0, 0, 0), "post_reset_evt");
    apply(mk(0,   0, 0, 1, 0,  0, 0, 0, 0,  0,  0, 0, 0), "post_reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dataover_event_tracker.md
# dataover_event_tracker

Receive-side consumer of the two-threshold comparator flags (over-100 / over-200). It encodes each sampled flag pair into a 3-zone level and detects zone crossings. Each crossing is buffered as a timestamped event record in a small FIFO, which a downstream reader drains over a valid/ready stream. It sits between the threshold comparator pair and the logging/FIFO path of the data monitor.

## Interface
Parameters:
- DATA_W, 32, width of the signed sample carried alongside the flags
- TS_W, 16, width of the free-running timestamp
- DEPTH, 4, event buffer entries; power of 2, ≥ 2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample strobe; flags and data are valid this cycle
- in_data  in  DATA_W  signed sample that produced the flags
- data_over_100  in  1  sample > 100
- data_over_200  in  1  sample > 200
- ev_valid  out  1  event record available
- ev_ready  in  1  reader accepts the event
- ev_level  out  2  new zone: 0 = ≤100, 1 = (100,200], 2 = >200
- ev_rising  out  1  1 if the new zone is above the old zone
- ev_ts  out  TS_W  timestamp of the crossing sample
- ev_data  out  DATA_W  in_data of the crossing sample
- overflow  out  1  sticky; an event was dropped
- flag_err  out  1  sticky; illegal flag pair seen
- drop_cnt  out  8  dropped-event count, saturates at 255
- clr_sticky  in  1  pulse; clears overflow, flag_err and drop_cnt

## Operation
- Zone encoding: {over_200, over_100} = 00→0, 01→1, 11→2. The pair 10 is illegal: flag_err is set, and the sample is ignored (no zone update, no event).
- Tracking FSM, reset state INIT:
  - INIT: the first legal in_valid sample loads prev_zone. No event is produced. Go to TRACK.
  - TRACK: each legal sample whose zone ≠ prev_zone pushes an event {zone, zone > prev_zone, ts, in_data} and updates prev_zone. A sample in the same zone does nothing.
- A jump from 0 to 2, or from 2 to 0, is one event, not two.
- Timestamp: ts counts up every clk from 0 after reset and wraps modulo 2^TS_W. An event carries the ts value of its sample cycle.
- Buffer: a FIFO of DEPTH entries. ev_* outputs present the head entry.
  - A pop occurs when ev_valid && ev_ready.
  - ev_data must stay stable while ev_valid && !ev_ready.
- Full buffer without a pop in the same cycle: the event is dropped, overflow is set, and drop_cnt increments (saturating). prev_zone still updates.
- Full buffer with a pop in the same cycle: the push is accepted and nothing is dropped.
- Empty buffer with a push: no bypass. The event is visible the next cycle.
- clr_sticky in the same cycle as a drop: the drop wins. overflow = 1 and drop_cnt = 1 afterwards.
- clr_sticky in the same cycle as an illegal pair: flag_err = 1.

## Timing
- Reset (asynchronous assert, synchronous release to the design):
  - ev_valid = 0; ev_level, ev_rising, ev_ts, ev_data = 0.
  - overflow, flag_err = 0; drop_cnt = 0; ts = 0.
  - FSM enters INIT and the buffer is emptied.
- Latency from a crossing sample to ev_valid = 1 cycle when the buffer is empty.
- Throughput: one push and one pop per cycle.
- Sticky outputs and drop_cnt are registered and update 1 cycle after the causing event.
- Reset mid-stream discards all buffered events. The next legal sample re-baselines in INIT and produces no event.
- in_valid = 0 cycles have no effect except ts advancing.

## Configuration
- DATAOVER_EVT_DATA_EN defined: ev_data is captured per event and stored in the buffer (entry width 2 + 1 + TS_W + DATA_W).
- DATAOVER_EVT_DATA_EN undefined:
  - ev_data is tied to 0 and no data storage is built (entry width 3 + TS_W).
  - in_data is unused.
  - All other behaviour is identical.

## Test plan
- Baseline, then rising, then falling:
  - Stimulus: after reset, samples 50 (00), 150 (01), 250 (11), 90 (00) on consecutive cycles, ev_ready = 1.
  - Required: no event for 50. Events follow: (level 1, rising 1, data 150), (level 2, rising 1, data 250), (level 0, rising 0, data 90). Each event has ts one greater than the previous.
- Overflow (DEPTH = 4):
  - Stimulus: ev_ready = 0. Alternate zones 0/1 for 6 crossings.
  - Required: 4 events buffered; overflow = 1; drop_cnt = 2. Then raise ev_ready: the first 4 crossings drain in order.
- Full buffer with simultaneous pop:
  - Stimulus: buffer full; ev_ready = 1 on the cycle a new crossing arrives.
  - Required: no drop; drop_cnt unchanged; buffer still full.
- Illegal flags:
  - Stimulus: in_valid with pair 10 while in zone 1.
  - Required: flag_err = 1, no event, zone stays 1. A following 01 sample produces no event. clr_sticky returns flag_err to 0.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 with 3 events buffered. Release it, then send sample 250.
  - Required: ev_valid = 0 and ts = 0 after reset. Sample 250 produces no event (INIT baseline); a following 50 produces (level 0, rising 0).
- Timestamp wrap:
  - Stimulus: TS_W = 4; crossings at ts = 14 and 2 cycles later.
  - Required: ev_ts = 14 and then 0.
